// File: rtl/word_normalizer_seq.sv
// word_normalizer_seq: multi-cycle left-justifying normaliser with valid/ready
// handshakes on both sides. One word is in flight at a time. In the default
// build the word shifts left by one bit per clock until its MSB is set.
// Optional macro WORD_NORMALIZER_NIBBLE_SKIP_EN lets a single clock shift by
// four whenever the top nibble is all zeros. The final results are the same
// either way; only the number of shift cycles changes.
module word_normalizer_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_shift,
  output logic             out_zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic [CNT_W-1:0] shift_nxt;
  logic             zero_nxt;

  // Next-state and working-register update; values hold unless a state acts on them.
  always_comb begin
    state_nxt = state;
    data_nxt  = out_data;
    shift_nxt = out_shift;
    zero_nxt  = out_zero;
    case (state)
      IDLE: begin
        // in_ready is high exactly in IDLE, so in_valid alone marks an accept.
        if (in_valid) begin
          data_nxt  = in_data;
          shift_nxt = '0;
          zero_nxt  = (in_data == '0);
          if ((in_data == '0) || in_data[WIDTH-1])
            state_nxt = DONE;
          else
            state_nxt = SHIFT;
        end
      end
      SHIFT: begin
`ifdef WORD_NORMALIZER_NIBBLE_SKIP_EN
        // A clear top nibble means at least four leading zeros remain.
        if (out_data[WIDTH-1 -: 4] == 4'd0) begin
          data_nxt  = out_data << 4;
          shift_nxt = out_shift + CNT_W'(4);
        end else begin
          data_nxt  = out_data << 1;
          shift_nxt = out_shift + CNT_W'(1);
        end
`else
        data_nxt  = out_data << 1;
        shift_nxt = out_shift + CNT_W'(1);
`endif
        // The word is never zero in SHIFT, so the MSB is eventually set.
        if (data_nxt[WIDTH-1])
          state_nxt = DONE;
      end
      DONE: begin
        if (out_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, the registered handshake flags and the result registers; reset discards any word in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_shift <= '0;
      out_zero  <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      out_data  <= data_nxt;
      out_shift <= shift_nxt;
      out_zero  <= zero_nxt;
    end
  end

endmodule

// File: tb/tb_word_normalizer_seq.sv
// Scoreboard bench for word_normalizer_seq: the driver pushes the expected
// result of every accepted word and a separate monitor pops and compares
// whenever the block presents a result.
module tb_word_normalizer_seq;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_shift;
  logic             out_zero;

  word_normalizer_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_shift(out_shift), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [CNT_W-1:0] s;
    logic             z;
    int               acc;
    int               lat;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int ready_mode = 1;  // 0 random, 1 always high, 2 held low

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: left-justify by counting leading zeros from the top bit.
  function automatic exp_t model(input logic [WIDTH-1:0] w, input int acc);
    exp_t e;
    int k = 0;
    if (w != 0) begin
      while (w[WIDTH-1-k] == 1'b0) k++;
    end
    e.d   = WIDTH'(int'(w) * (2 ** k));
    e.s   = CNT_W'(k);
    e.z   = (w == 0);
    e.acc = acc;
`ifdef WORD_NORMALIZER_NIBBLE_SKIP_EN
    e.lat = k / 4 + k % 4;
`else
    e.lat = k;
`endif
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // out_ready changes just after each rising edge
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = ($urandom_range(0, 3) != 0);
      1:       out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor
  logic             prev_v = 1'b0;
  logic             exp_idle = 1'b0;
  logic [WIDTH-1:0] snap_d;
  logic [CNT_W-1:0] snap_s;
  logic             snap_z;
  always @(negedge clk) begin
    if (reset) begin
      prev_v   = 1'b0;
      exp_idle = 1'b0;
    end else begin
      if (exp_idle) begin
        chk("handoff_valid_drop", {31'd0, out_valid}, 32'd0);
        chk("handoff_ready_rise", {31'd0, in_ready}, 32'd1);
        exp_idle = 1'b0;
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          if (!prev_v) begin
            chk("latency", cyc - q[0].acc, q[0].lat);
            snap_d = out_data;
            snap_s = out_shift;
            snap_z = out_zero;
          end else begin
            chk("hold_data", {24'd0, out_data}, {24'd0, snap_d});
            chk("hold_shift", {28'd0, out_shift}, {28'd0, snap_s});
            chk("hold_zero", {31'd0, out_zero}, {31'd0, snap_z});
          end
          chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
          if (out_ready) begin
            chk("out_data", {24'd0, out_data}, {24'd0, q[0].d});
            chk("out_shift", {28'd0, out_shift}, {28'd0, q[0].s});
            chk("out_zero", {31'd0, out_zero}, {31'd0, q[0].z});
            void'(q.pop_front());
            exp_idle = 1'b1;
          end
        end
      end
      prev_v = out_valid;
    end
  end

  // Offer one word and hold it until accepted.
  task automatic send(input logic [WIDTH-1:0] w);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    end else begin
      q.push_back(model(w, cyc + 1));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = WIDTH'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_shift", {28'd0, out_shift}, 32'd0);
    chk("rst_out_zero", {31'd0, out_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed words
    ready_mode = 1;
    send(8'h96);
    drain();
    send(8'h01);
    drain();
    send(8'h00);
    drain();

    // Backpressure for several cycles
    ready_mode = 2;
    send(8'h13);
    begin
      int n = 0;
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("wait_valid_13", {31'd0, out_valid}, 32'd1);
    end
    repeat (5) @(negedge clk);
    ready_mode = 1;
    drain();

    // Back-to-back offers
    send(8'h40);
    send(8'h0C);
    drain();

    // Reset while shifting
    send(8'h01);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    q.delete();
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_data", {24'd0, out_data}, 32'd0);
    chk("post_rst_shift", {28'd0, out_shift}, 32'd0);

    // Randomized words with random backpressure
    ready_mode = 0;
    for (int i = 0; i < 80; i++) begin
      logic [WIDTH-1:0] w;
      w = WIDTH'($urandom_range(0, 255) >> $urandom_range(0, 7));
      send(w);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    ready_mode = 1;
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
